// File: rtl/interrupt_entry_sequencer.sv
// ARM-style exception-entry sequencer: waits for an instruction boundary, then flushes,
// saves CPSR to SPSR, writes the banked LR, updates CPSR and loads the vector PC.
module interrupt_entry_sequencer #(
    parameter int unsigned              ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]    FIQ_VECTOR = 'h0000001C,
    parameter logic [ADDR_WIDTH-1:0]    IRQ_VECTOR = 'h00000018,
    parameter int unsigned              LR_OFFSET  = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  TrueFiq,
    input  logic                  TrueIrq,
    input  logic                  InstrBoundary,
    input  logic [ADDR_WIDTH-1:0] CurrentPC,
    input  logic [31:0]           CPSRIn,
    input  logic                  RegWriteReady,
    output logic                  FlushPipeline,
    output logic                  SPSRWrite,
    output logic [31:0]           SPSRData,
    output logic                  LRWrite,
    output logic [ADDR_WIDTH-1:0] LRData,
    output logic                  CPSRWrite,
    output logic [31:0]           CPSRData,
    output logic                  PCLoad,
    output logic [ADDR_WIDTH-1:0] PCData,
    output logic                  EntryBusy,
    output logic                  EntryIsFiq
);

    typedef enum logic [2:0] {
        StIdle,
        StFlush,
        StSaveSpsr,
        StWriteLr,
        StSetCpsr,
        StVector
    } state_e;

    state_e                state_q, state_d;
    logic                  is_fiq_q, is_fiq_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [31:0]           cpsr_q, cpsr_d;
    logic [31:0]           cpsr_new;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= StIdle;
            is_fiq_q <= 1'b0;
            pc_q     <= '0;
            cpsr_q   <= '0;
        end else begin
            state_q  <= state_d;
            is_fiq_q <= is_fiq_d;
            pc_q     <= pc_d;
            cpsr_q   <= cpsr_d;
        end
    end

    // New mode, Thumb cleared, IRQ masked; FIQ additionally masks FIQ.
    always_comb begin
        cpsr_new      = cpsr_q;
        cpsr_new[4:0] = is_fiq_q ? 5'b10001 : 5'b10010;
        cpsr_new[5]   = 1'b0;
        cpsr_new[7]   = 1'b1;
        if (is_fiq_q) begin
            cpsr_new[6] = 1'b1;
        end
    end

    always_comb begin
        state_d       = state_q;
        is_fiq_d      = is_fiq_q;
        pc_d          = pc_q;
        cpsr_d        = cpsr_q;
        FlushPipeline = 1'b0;
        SPSRWrite     = 1'b0;
        SPSRData      = '0;
        LRWrite       = 1'b0;
        LRData        = '0;
        CPSRWrite     = 1'b0;
        CPSRData      = '0;
        PCLoad        = 1'b0;
        PCData        = '0;

        unique case (state_q)
            StIdle: begin
                if (InstrBoundary && (TrueFiq || TrueIrq)) begin
                    state_d  = StFlush;
                    is_fiq_d = TrueFiq;
                    pc_d     = CurrentPC;
                    cpsr_d   = CPSRIn;
                end
            end
            StFlush: begin
                FlushPipeline = 1'b1;
                state_d       = StSaveSpsr;
            end
            StSaveSpsr: begin
                SPSRWrite = 1'b1;
                SPSRData  = cpsr_q;
                if (RegWriteReady) begin
                    state_d = StWriteLr;
                end
            end
            StWriteLr: begin
                LRWrite = 1'b1;
                LRData  = pc_q + ADDR_WIDTH'(LR_OFFSET);
                if (RegWriteReady) begin
                    state_d = StSetCpsr;
                end
            end
            StSetCpsr: begin
                CPSRWrite = 1'b1;
                CPSRData  = cpsr_new;
                state_d   = StVector;
            end
            StVector: begin
                PCLoad  = 1'b1;
                PCData  = is_fiq_q ? FIQ_VECTOR : IRQ_VECTOR;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign EntryBusy  = (state_q != StIdle);
    assign EntryIsFiq = EntryBusy & is_fiq_q;

endmodule

// File: tb/tb_interrupt_entry_sequencer.sv
// Scoreboard bench: stimulus queues expected strobe events and idle cycles; a negedge monitor
// pops and compares them against what the sequencer presents.
module tb_interrupt_entry_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        TrueFiq, TrueIrq, InstrBoundary, RegWriteReady;
    logic [31:0] CurrentPC, CPSRIn;
    logic        FlushPipeline, SPSRWrite, LRWrite, CPSRWrite, PCLoad, EntryBusy, EntryIsFiq;
    logic [31:0] SPSRData, LRData, CPSRData, PCData;

    always #5 clock = ~clock;

    interrupt_entry_sequencer dut (
        .clock         (clock),
        .reset         (reset),
        .TrueFiq       (TrueFiq),
        .TrueIrq       (TrueIrq),
        .InstrBoundary (InstrBoundary),
        .CurrentPC     (CurrentPC),
        .CPSRIn        (CPSRIn),
        .RegWriteReady (RegWriteReady),
        .FlushPipeline (FlushPipeline),
        .SPSRWrite     (SPSRWrite),
        .SPSRData      (SPSRData),
        .LRWrite       (LRWrite),
        .LRData        (LRData),
        .CPSRWrite     (CPSRWrite),
        .CPSRData      (CPSRData),
        .PCLoad        (PCLoad),
        .PCData        (PCData),
        .EntryBusy     (EntryBusy),
        .EntryIsFiq    (EntryIsFiq)
    );

    typedef struct {
        logic [4:0]  strb;   // {PCLoad, CPSRWrite, LRWrite, SPSRWrite, FlushPipeline}
        logic [31:0] data;
        int          cyc;
        logic        fiq;
    } exp_t;

    exp_t        exp_q[$];
    int          idle_q[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic        mon_en = 1'b0;
    logic        done = 1'b0;
    exp_t        e;
    logic [4:0]  strb;
    logic [31:0] act_data;
    logic        leak;
    int          c;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (mon_en) begin
            strb = {PCLoad, CPSRWrite, LRWrite, SPSRWrite, FlushPipeline};
            leak = (!SPSRWrite && SPSRData != 0) || (!LRWrite && LRData != 0) ||
                   (!CPSRWrite && CPSRData != 0) || (!PCLoad && PCData != 0);
            checks++;
            if (!$onehot0(strb) || leak) begin
                errors++;
                $display("FAIL strobe_hygiene cyc=%0d: strobes=%b leak=%b, required one-hot and no leak",
                         cyc, strb, leak);
            end
            if (strb != 5'd0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_strobe cyc=%0d: strobes=%b, required none", cyc, strb);
                end else begin
                    e = exp_q.pop_front();
                    if (SPSRWrite)      act_data = SPSRData;
                    else if (LRWrite)   act_data = LRData;
                    else if (CPSRWrite) act_data = CPSRData;
                    else if (PCLoad)    act_data = PCData;
                    else                act_data = 32'h0;
                    if (strb !== e.strb || act_data !== e.data || cyc != e.cyc ||
                        EntryIsFiq !== e.fiq || EntryBusy !== 1'b1) begin
                        errors++;
                        $display("FAIL event: got strb=%b data=%h cyc=%0d fiq=%b busy=%b, required strb=%b data=%h cyc=%0d fiq=%b busy=1",
                                 strb, act_data, cyc, EntryIsFiq, EntryBusy,
                                 e.strb, e.data, e.cyc, e.fiq);
                    end
                end
            end
            while (idle_q.size() > 0 && idle_q[0] <= cyc) begin
                c = idle_q.pop_front();
                checks++;
                if (c != cyc || {EntryBusy, EntryIsFiq, strb} !== 7'd0) begin
                    errors++;
                    $display("FAIL idle cyc=%0d (wanted at %0d): busy=%b fiq=%b strobes=%b, required all 0",
                             cyc, c, EntryBusy, EntryIsFiq, strb);
                end
            end
            if (done) begin
                checks++;
                if (exp_q.size() != 0 || idle_q.size() != 0) begin
                    errors++;
                    $display("FAIL leftover: events=%0d idles=%0d pending, required 0 and 0",
                             exp_q.size(), idle_q.size());
                end
                $display("Result: errors=%0d of %0d checks", errors, checks);
                $finish;
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_idle();
        idle_q.push_back(cyc);
    endtask

    // Queue the strobe sequence for an entry whose accept edge leads into cycle a.
    task automatic push_expect(input logic f, input logic [31:0] spsr, input logic [31:0] lr,
                               input logic [31:0] ncpsr, input int a, input int stall,
                               input logic full);
        exp_q.push_back('{5'b00001, 32'h0, a, f});
        for (int i = 0; i <= stall; i++) exp_q.push_back('{5'b00010, spsr, a + 1 + i, f});
        exp_q.push_back('{5'b00100, lr, a + stall + 2, f});
        if (full) begin
            exp_q.push_back('{5'b01000, ncpsr, a + stall + 3, f});
            exp_q.push_back('{5'b10000, f ? 32'h1C : 32'h18, a + stall + 4, f});
        end
    endtask

    task automatic entry(input logic f, input logic i, input logic [31:0] pc,
                         input logic [31:0] cpsr, input logic [31:0] lr,
                         input logic [31:0] ncpsr, input int stall);
        int a;
        TrueFiq = f; TrueIrq = i; InstrBoundary = 1'b1;
        CurrentPC = pc; CPSRIn = cpsr; RegWriteReady = 1'b1;
        a = cyc + 1;
        push_expect(f | 1'b0, cpsr, lr, ncpsr, a, stall, 1'b1);
        step();
        TrueFiq = 1'b0; TrueIrq = 1'b0; InstrBoundary = 1'b0;
        CurrentPC = 32'hDEAD_BEEF; CPSRIn = 32'hFFFF_FFFF;
        RegWriteReady = (stall == 0);
        repeat (stall + 1) step();
        RegWriteReady = 1'b1;
        repeat (4) step();
        expect_idle();
    endtask

    initial begin
        int a;
        reset = 1'b1; TrueFiq = 1'b0; TrueIrq = 1'b0; InstrBoundary = 1'b0;
        CurrentPC = '0; CPSRIn = '0; RegWriteReady = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        mon_en = 1'b1;
        expect_idle();
        step();

        entry(1'b0, 1'b1, 32'h0000_1000, 32'h0000_0010, 32'h0000_1004, 32'h0000_0092, 0);
        entry(1'b1, 1'b1, 32'h0000_0400, 32'h0000_00D3, 32'h0000_0404, 32'h0000_00D1, 0);
        entry(1'b1, 1'b1, 32'h0000_0800, 32'h0000_00F3, 32'h0000_0804, 32'h0000_00D1, 0);

        // Request without a boundary must not be taken.
        TrueIrq = 1'b1; InstrBoundary = 1'b0;
        repeat (3) begin
            step();
            expect_idle();
        end
        entry(1'b0, 1'b1, 32'h1234_5678, 32'hA000_0053, 32'h1234_567C, 32'hA000_00D2, 2);

        // IRQ pulse at accept, FIQ rising mid-sequence is taken back-to-back afterwards.
        TrueIrq = 1'b1; TrueFiq = 1'b0; InstrBoundary = 1'b1; RegWriteReady = 1'b1;
        CurrentPC = 32'h0000_2000; CPSRIn = 32'h0000_0010;
        a = cyc + 1;
        push_expect(1'b0, 32'h0000_0010, 32'h0000_2004, 32'h0000_0092, a, 0, 1'b1);
        step();
        TrueIrq = 1'b0; CurrentPC = 32'hDEAD_BEEF; CPSRIn = 32'hFFFF_FFFF;
        step();
        TrueFiq = 1'b1; CurrentPC = 32'h0000_3000; CPSRIn = 32'h6000_0013;
        push_expect(1'b1, 32'h6000_0013, 32'h0000_3004, 32'h6000_00D1, a + 6, 0, 1'b1);
        repeat (4) step();
        expect_idle();
        step();
        TrueFiq = 1'b0; InstrBoundary = 1'b0;
        repeat (5) step();
        expect_idle();

        entry(1'b1, 1'b0, 32'hFFFF_FFFE, 32'h0000_003F, 32'h0000_0002, 32'h0000_00D1, 0);

        // Reset while in WRITE_LR abandons the sequence.
        TrueIrq = 1'b1; InstrBoundary = 1'b1; RegWriteReady = 1'b1;
        CurrentPC = 32'h0000_5000; CPSRIn = 32'h0000_0010;
        a = cyc + 1;
        push_expect(1'b0, 32'h0000_0010, 32'h0000_5004, 32'h0, a, 0, 1'b0);
        step();
        TrueIrq = 1'b0; InstrBoundary = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (4) begin
            expect_idle();
            step();
        end

        done = 1'b1;
        repeat (3) step();
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1, "timeout");
    end

endmodule
